bus_xfer_ctrl: RTL and testbench

BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

---
 rtl/bus_ctrl_pkg.sv | 32 +++
 rtl/rr_arb2.sv | 22 ++
 rtl/bus_xfer_ctrl.sv | 131 +++++++++++++
 tb/tb_bus_xfer_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_ctrl_pkg.sv
// Shared types and constants for the register-to-register bus transfer controller.
package bus_ctrl_pkg;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned NUM_REG = 4;
    localparam int unsigned IDX_W   = 2;

    // Register file indices on the shared 8-bit bus
    localparam logic [IDX_W-1:0] REG_A   = IDX_W'(0);
    localparam logic [IDX_W-1:0] REG_B   = IDX_W'(1);
    localparam logic [IDX_W-1:0] REG_IR  = IDX_W'(2);
    localparam logic [IDX_W-1:0] REG_OUT = IDX_W'(3);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_LATCH  = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    // Source/destination pair latched at grant time
    typedef struct packed {
        logic [IDX_W-1:0] src;
        logic [IDX_W-1:0] dst;
    } xfer_t;

    // One-hot select for a register index
    function automatic logic [NUM_REG-1:0] reg_onehot(input logic [IDX_W-1:0] idx);
        return NUM_REG'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: ptr_i names the requester favoured on a tie.
module rr_arb2
    import bus_ctrl_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               ptr_i,
    output logic [NUM_REQ-1:0] gnt_c
);

    // Lone requester always wins; both active resolves to the pointer
    always_comb begin
        gnt_c = '0;
        if (req_i[0] && req_i[1]) begin
            gnt_c = ptr_i ? 2'b10 : 2'b01;
        end else if (req_i[0]) begin
            gnt_c = 2'b01;
        end else if (req_i[1]) begin
            gnt_c = 2'b10;
        end
    end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Sequences one register-to-register copy over a shared bus per grant:
// drive source for a settle cycle, strobe destination, then signal done.
module bus_xfer_ctrl
    import bus_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [IDX_W-1:0]    src0,
    input  logic [IDX_W-1:0]    dst0,
    input  logic [IDX_W-1:0]    src1,
    input  logic [IDX_W-1:0]    dst1,
    output logic [NUM_REG-1:0]  reg_enable,
    output logic [NUM_REG-1:0]  reg_load,
    output logic [NUM_REQ-1:0]  grant,
    output logic [NUM_REQ-1:0]  done,
    output logic                err,
    output logic                busy
);

    state_e              state_q, state_d;
    xfer_t               xfer_q, xfer_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic                ptr_q, ptr_d;
    logic [NUM_REG-1:0]  reg_enable_q, reg_enable_d;
    logic [NUM_REG-1:0]  reg_load_q, reg_load_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic [NUM_REQ-1:0]  arb_gnt;

    rr_arb2 u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_c (arb_gnt)
    );

    // Next state plus output decode from the upcoming state, so outputs register in step with it
    always_comb begin
        state_d      = state_q;
        xfer_d       = xfer_q;
        grant_d      = grant_q;
        ptr_d        = ptr_q;
        reg_enable_d = '0;
        reg_load_d   = '0;
        done_d       = '0;
        err_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_DRIVE;
                    grant_d = arb_gnt;
                    // Next tie goes to whoever did not just win
                    ptr_d   = arb_gnt[0];
                    if (arb_gnt[1]) begin
                        xfer_d.src = src1;
                        xfer_d.dst = dst1;
                    end else begin
                        xfer_d.src = src0;
                        xfer_d.dst = dst0;
                    end
                end
            end
            ST_DRIVE:  state_d = ST_LATCH;
            ST_LATCH:  state_d = ST_FINISH;
            ST_FINISH: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);

        case (state_d)
            ST_DRIVE: begin
                reg_enable_d = reg_onehot(xfer_d.src);
            end
            ST_LATCH: begin
                reg_enable_d = reg_onehot(xfer_d.src);
                // Self-copy is illegal: keep the strobe off
                if (xfer_d.src != xfer_d.dst) begin
                    reg_load_d = reg_onehot(xfer_d.dst);
                end
            end
            ST_FINISH: begin
                done_d = grant_d;
                err_d  = (xfer_d.src == xfer_d.dst);
            end
            default: begin
            end
        endcase
    end

    // State, latched transfer and registered outputs; reset aborts any transfer in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            xfer_q       <= '0;
            grant_q      <= '0;
            ptr_q        <= 1'b0;
            reg_enable_q <= '0;
            reg_load_q   <= '0;
            done_q       <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            xfer_q       <= xfer_d;
            grant_q      <= grant_d;
            ptr_q        <= ptr_d;
            reg_enable_q <= reg_enable_d;
            reg_load_q   <= reg_load_d;
            done_q       <= done_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    assign reg_enable = reg_enable_q;
    assign reg_load   = reg_load_q;
    assign grant      = grant_q;
    assign done       = done_q;
    assign err        = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Self-checking bench for bus_xfer_ctrl with an external 4x8-bit register file on a shared bus.
module tb_bus_xfer_ctrl;

    typedef struct packed {
        logic [3:0] en;
        logic [3:0] ld;
        logic [1:0] gnt;
        logic [1:0] dn;
        logic       er;
        logic       bsy;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [1:0] src0, dst0, src1, dst1;
    logic [3:0] reg_enable, reg_load;
    logic [1:0] grant, done;
    logic       err, busy;

    bus_xfer_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .src0       (src0),
        .dst0       (dst0),
        .src1       (src1),
        .dst1       (dst1),
        .reg_enable (reg_enable),
        .reg_load   (reg_load),
        .grant      (grant),
        .done       (done),
        .err        (err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External register file driven by the controller's strobes
    logic [7:0] regq [4];
    logic [7:0] bus;
    logic       pre_en;
    logic [1:0] pre_idx;
    logic [7:0] pre_val;

    always_comb begin
        bus = 8'h00;
        for (int i = 0; i < 4; i++) if (reg_enable[i]) bus = bus | regq[i];
    end

    always @(posedge clk) begin
        if (pre_en) regq[pre_idx] <= pre_val;
        else for (int i = 0; i < 4; i++) if (reg_load[i]) regq[i] <= bus;
    end

    // Reference model: transaction schedule keyed by edge count
    exp_t       slots [8];
    exp_t       exp_now;
    int         ecnt;
    int         next_free;
    int         favored;
    logic [7:0] exp_reg [4];
    bit         pend_valid;
    int         pend_edge;
    int         pend_src, pend_dst;
    int         n_checks;
    int         n_fail;

    function automatic exp_t obs();
        exp_t o;
        o = {reg_enable, reg_load, grant, done, err, busy};
        return o;
    endfunction

    task automatic model_edge();
        int         win, s, d;
        logic [3:0] ohs, ohd;
        logic [1:0] g;
        ecnt++;
        if (pend_valid && ecnt == pend_edge) begin
            exp_reg[pend_dst] = exp_reg[pend_src];
            pend_valid = 1'b0;
        end
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) slots[i] = '0;
            favored    = 0;
            next_free  = ecnt + 1;
            pend_valid = 1'b0;
        end else if (ecnt >= next_free && req != 2'b00) begin
            if (req == 2'b11) win = favored;
            else              win = req[1] ? 1 : 0;
            favored = (win == 0) ? 1 : 0;
            s   = (win == 1) ? int'(src1) : int'(src0);
            d   = (win == 1) ? int'(dst1) : int'(dst0);
            ohs = 4'b0001 << s;
            ohd = 4'b0001 << d;
            g   = (win == 1) ? 2'b10 : 2'b01;
            slots[ecnt & 7]       = {ohs, 4'b0000, g, 2'b00, 1'b0, 1'b1};
            slots[(ecnt + 1) & 7] = {ohs, (s != d) ? ohd : 4'b0000, g, 2'b00, 1'b0, 1'b1};
            slots[(ecnt + 2) & 7] = {4'b0000, 4'b0000, g, g, (s == d), 1'b1};
            next_free = ecnt + 4;
            if (s != d) begin
                pend_valid = 1'b1;
                pend_edge  = ecnt + 2;
                pend_src   = s;
                pend_dst   = d;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        exp_now = slots[ecnt & 7];
        slots[ecnt & 7] = '0;
    endtask

    task automatic preload(input int idx, input logic [7:0] val);
        pre_en  = 1'b1;
        pre_idx = 2'(idx);
        pre_val = val;
        tick();
        pre_en  = 1'b0;
        exp_reg[idx] = val;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 2'b00;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (obs() !== 14'h0) begin
                n_fail++;
                $display("FAIL reset cyc=%0d got=%h exp=0", ecnt, obs());
            end
        end
        for (int i = 0; i < 4; i++) preload(i, 8'($urandom));
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        exp_t o;
        preload(0, 8'hAB);
        src0 = 2'd0; dst0 = 2'd1; req = 2'b01;
        for (int c = 0; c < 3; c++) begin
            tick();
            o = obs();
            n_checks++;
            if (o !== exp_now) begin
                n_fail++;
                $display("FAIL single cyc=%0d got=%h exp=%h", c, o, exp_now);
            end
            n_checks++;
            if ((c < 2 && o.en !== 4'b0001) || (c == 2 && o.en !== 4'b0000)) begin
                n_fail++;
                $display("FAIL single_enable cyc=%0d got=%b", c, o.en);
            end
            if (c == 2) begin
                n_checks++;
                if (o.dn !== 2'b01) begin
                    n_fail++;
                    $display("FAIL single_done got=%b exp=01", o.dn);
                end
                req = 2'b00;
            end
        end
        tick();
        n_checks++;
        if (regq[1] !== 8'hAB || exp_reg[1] !== 8'hAB) begin
            n_fail++;
            $display("FAIL single_data regB=%h model=%h exp=ab", regq[1], exp_reg[1]);
        end
    endtask

    task automatic test_contention();
        logic [1:0] seen [4];
        logic [1:0] want [4];
        int         nd;
        want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01; want[3] = 2'b10;
        nd = 0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 2'b11;
        for (int c = 0; c < 16; c++) begin
            src0 = 2'($urandom); dst0 = 2'($urandom);
            src1 = 2'($urandom); dst1 = 2'($urandom);
            tick();
            n_checks++;
            if (obs() !== exp_now) begin
                n_fail++;
                $display("FAIL contention cyc=%0d got=%h exp=%h", c, obs(), exp_now);
            end
            if (done != 2'b00 && nd < 4) begin
                seen[nd] = grant;
                nd++;
            end
        end
        req = 2'b00;
        n_checks++;
        if (nd != 4) begin
            n_fail++;
            $display("FAIL contention_count got=%0d exp=4", nd);
        end
        for (int i = 0; i < nd; i++) begin
            n_checks++;
            if (seen[i] !== want[i]) begin
                n_fail++;
                $display("FAIL contention_order idx=%0d got=%b exp=%b", i, seen[i], want[i]);
            end
        end
        tick();
    endtask

    task automatic test_illegal();
        logic [7:0] ir_before;
        ir_before = regq[2];
        src1 = 2'd2; dst1 = 2'd2; req = 2'b10;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (obs() !== exp_now || reg_load !== 4'b0000) begin
                n_fail++;
                $display("FAIL illegal cyc=%0d got=%h exp=%h", c, obs(), exp_now);
            end
        end
        n_checks++;
        if (err !== 1'b1 || done !== 2'b10) begin
            n_fail++;
            $display("FAIL illegal_flags err=%b done=%b exp err=1 done=10", err, done);
        end
        req = 2'b00;
        tick();
        n_checks++;
        if (regq[2] !== ir_before) begin
            n_fail++;
            $display("FAIL illegal_ir got=%h exp=%h", regq[2], ir_before);
        end
    endtask

    task automatic test_midchange();
        src0 = 2'd1; dst0 = 2'd3; req = 2'b01;
        tick();
        src0 = 2'd2; dst0 = 2'd0; req = 2'b00;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if (obs() !== exp_now) begin
                n_fail++;
                $display("FAIL midchange cyc=%0d got=%h exp=%h", c, obs(), exp_now);
            end
        end
        n_checks++;
        if (done !== 2'b01) begin
            n_fail++;
            $display("FAIL midchange_done got=%b exp=01", done);
        end
        tick();
        n_checks++;
        if (regq[3] !== exp_reg[3] || exp_reg[3] !== exp_reg[1]) begin
            n_fail++;
            $display("FAIL midchange_data got=%h exp=%h", regq[3], exp_reg[1]);
        end
    endtask

    task automatic test_reset_abort();
        src1 = 2'd3; dst1 = 2'd0; req = 2'b10;
        tick();
        tick();
        rst_n = 1'b0;
        req   = 2'b00;
        tick();
        n_checks++;
        if (obs() !== 14'h0 || exp_now !== 14'h0) begin
            n_fail++;
            $display("FAIL abort got=%h exp=0", obs());
        end
        rst_n = 1'b1;
        req   = 2'b10;
        src1  = 2'd0; dst1 = 2'd2;
        tick();
        n_checks++;
        if (grant !== 2'b10 || obs() !== exp_now) begin
            n_fail++;
            $display("FAIL abort_regrant got=%h exp=%h", obs(), exp_now);
        end
        tick();
        tick();
        req = 2'b00;
        tick();
    endtask

    task automatic test_idle();
        req = 2'b00;
        for (int c = 0; c < 10; c++) begin
            src0 = 2'($urandom); dst0 = 2'($urandom);
            tick();
            n_checks++;
            if (obs() !== 14'h0 || exp_now !== 14'h0) begin
                n_fail++;
                $display("FAIL idle cyc=%0d got=%h exp=0", c, obs());
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (regq[i] !== exp_reg[i]) begin
                n_fail++;
                $display("FAIL idle_reg idx=%0d got=%h exp=%h", i, regq[i], exp_reg[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req   = 2'($urandom);
            src0  = 2'($urandom); dst0 = 2'($urandom);
            src1  = 2'($urandom); dst1 = 2'($urandom);
            rst_n = ($urandom_range(0, 63) != 0);
            tick();
            n_checks++;
            if (obs() !== exp_now) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%h exp=%h", c, obs(), exp_now);
            end
        end
        rst_n = 1'b1;
        req   = 2'b00;
        for (int c = 0; c < 4; c++) tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (regq[i] !== exp_reg[i]) begin
                n_fail++;
                $display("FAIL random_reg idx=%0d got=%h exp=%h", i, regq[i], exp_reg[i]);
            end
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        ecnt       = 0;
        next_free  = 0;
        favored    = 0;
        pend_valid = 1'b0;
        pend_edge  = 0;
        pend_src   = 0;
        pend_dst   = 0;
        for (int i = 0; i < 8; i++) slots[i] = '0;
        for (int i = 0; i < 4; i++) exp_reg[i] = 8'h00;
        exp_now = '0;
        pre_en  = 1'b0;
        pre_idx = 2'd0;
        pre_val = 8'h00;
        rst_n   = 1'b0;
        req     = 2'b00;
        src0 = 2'd0; dst0 = 2'd0; src1 = 2'd0; dst1 = 2'd0;

        test_reset();
        test_single();
        test_contention();
        test_illegal();
        test_midchange();
        test_reset_abort();
        test_idle();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
